// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and link-wide constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned UART_DEFAULT_BIT_CYCLES = 434;
  localparam int unsigned UART_DATA_BITS          = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus a history flop for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic n_Rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Reset to the idle-high line level so no false start edge appears after reset.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: mid-bit sampling FSM with ready/ack handshake and error flags.
module uart_receive
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = UART_DEFAULT_BIT_CYCLES,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       n_Rst,
  input  logic       serial_in,
  input  logic       rx_enable,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam logic [9:0] HALF_LAST    = 10'(HALF_CYCLES - 1);
  localparam logic [9:0] BIT_LAST     = 10'(BIT_CYCLES - 1);
  localparam logic [2:0] BIT_IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic sync, fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .n_Rst    (n_Rst),
    .async_in (serial_in),
    .sync_out (sync),
    .fall     (fall)
  );

  rx_state_e                 state_q, state_d;
  logic [9:0]                cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                data_q, data_d;
  logic                      ready_q, ready_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;

  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (data_read && ready_q) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    if (!rx_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = sync ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {sync, shift_q[UART_DATA_BITS-1:1]};
            if (bit_q == BIT_IDX_LAST) state_d = STOP;
            else                       bit_d   = bit_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            // Completion overrides a same-cycle ack: new byte stays ready, overrun cleared.
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            data_d  = shift_q;
            ready_d = 1'b1;
            ferr_d  = ~sync;
            ovr_d   = ready_q & ~data_read;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out      = data_q;
  assign data_ready    = ready_q;
  assign framing_error = ferr_q;
  assign overrun_error = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: directed frames at 16 cycles/bit plus one frame at 434.
module tb_uart_receive;

  localparam int BIT  = 16;
  localparam int HALF = BIT / 2;
  localparam int LAT  = HALF + 9 * BIT + 3;

  logic       clk = 1'b0;
  logic       n_Rst, serial_in, rx_enable, data_read;
  logic [7:0] data_out;
  logic       data_ready, framing_error, overrun_error, busy;

  logic       n_Rst2, serial2;
  logic [7:0] data_out2;
  logic       data_ready2, framing_error2, overrun_error2, busy2;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [7:0]  data;
    logic        ferr;
    logic        ovr;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  uart_receive #(.BIT_CYCLES(BIT)) u_dut (
    .clk           (clk),
    .n_Rst         (n_Rst),
    .serial_in     (serial_in),
    .rx_enable     (rx_enable),
    .data_read     (data_read),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  uart_receive #(.BIT_CYCLES(434)) u_dut434 (
    .clk           (clk),
    .n_Rst         (n_Rst2),
    .serial_in     (serial2),
    .rx_enable     (1'b1),
    .data_read     (1'b0),
    .data_out      (data_out2),
    .data_ready    (data_ready2),
    .framing_error (framing_error2),
    .overrun_error (overrun_error2),
    .busy          (busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
  endtask

  // Full frame; expectation pushed before the start bit goes out.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic rd_done,
                            input logic exp_ferr, input logic exp_ovr);
    exp_t e;
    e.data = d; e.ferr = exp_ferr; e.ovr = exp_ovr; e.cyc = cyc + LAT;
    sb.push_back(e);
    serial_in = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      tick(BIT);
    end
    serial_in = stopb;
    if (rd_done) begin
      tick(2 + HALF);
      data_read = 1'b1;
      tick(1);
      data_read = 1'b0;
      tick(BIT - 3 - HALF);
    end else begin
      tick(BIT);
    end
    serial_in = 1'b1;
  endtask

  // Monitor: a byte is presented when data_ready rises or data_out changes while ready.
  logic       mon_prev_rdy = 1'b0;
  logic [7:0] mon_prev_dat = 8'h00;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_ready === 1'b1 && (!mon_prev_rdy || data_out !== mon_prev_dat)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h, expected none", data_out);
        end else begin
          e = sb.pop_front();
          chk("sb_data", {24'd0, data_out}, {24'd0, e.data});
          chk("sb_ferr", {31'd0, framing_error}, {31'd0, e.ferr});
          chk("sb_ovr", {31'd0, overrun_error}, {31'd0, e.ovr});
          chk("sb_latency", cyc, e.cyc);
        end
      end
      mon_prev_rdy = data_ready;
      mon_prev_dat = data_out;
    end
  end

  // 434-cycle instance: one frame 0xC3, latency and contents checked directly.
  int unsigned rise2 = 0;
  logic        prev2 = 1'b0;
  logic        done434 = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (data_ready2 === 1'b1 && !prev2 && rise2 == 0) rise2 = cyc;
      prev2 = data_ready2;
    end
  end

  initial begin
    logic [7:0]  d2;
    int unsigned n2;
    d2 = 8'hC3;
    n_Rst2 = 1'b0;
    serial2 = 1'b1;
    tick(3);
    n_Rst2 = 1'b1;
    tick(10);
    n2 = cyc;
    serial2 = 1'b0;
    tick(434);
    for (int i = 0; i < 8; i++) begin
      serial2 = d2[i];
      tick(434);
    end
    serial2 = 1'b1;
    tick(434);
    chk("b434_latency", rise2, n2 + 217 + 9 * 434 + 3);
    chk("b434_data", {24'd0, data_out2}, 32'h0000_00C3);
    chk("b434_ferr", {31'd0, framing_error2}, 32'd0);
    done434 = 1'b1;
  end

  initial begin
    logic [7:0] d;
    n_Rst = 1'b0;
    serial_in = 1'b1;
    rx_enable = 1'b1;
    data_read = 1'b0;
    tick(3);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_ferr", {31'd0, framing_error}, 32'd0);
    chk("rst_ovr", {31'd0, overrun_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    n_Rst = 1'b1;
    tick(20);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_ready_held", {31'd0, data_ready}, 32'd1);
    read_pulse();
    chk("a5_ready_clr", {31'd0, data_ready}, 32'd0);
    tick(5);

    serial_in = 1'b0;
    tick(4);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    tick(1);
    serial_in = 1'b1;
    tick(15);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    chk("glitch_ready", {31'd0, data_ready}, 32'd0);
    chk("glitch_ferr", {31'd0, framing_error}, 32'd0);
    chk("glitch_ovr", {31'd0, overrun_error}, 32'd0);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    read_pulse();
    chk("fe_ready_clr", {31'd0, data_ready}, 32'd0);
    chk("fe_ferr_clr", {31'd0, framing_error}, 32'd0);
    chk("fe_ovr_clr", {31'd0, overrun_error}, 32'd0);
    tick(5);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(3);
    read_pulse();
    chk("ovr_clr", {31'd0, overrun_error}, 32'd0);
    tick(5);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk("rdsame_ready", {31'd0, data_ready}, 32'd1);
    chk("rdsame_ovr", {31'd0, overrun_error}, 32'd0);
    read_pulse();
    tick(5);

    d = 8'h5A;
    serial_in = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      if (i == 4) begin
        tick(HALF);
        rx_enable = 1'b0;
        tick(1);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        tick(BIT - HALF - 1);
      end else begin
        tick(BIT);
      end
    end
    serial_in = 1'b1;
    tick(BIT);
    chk("dis_ready", {31'd0, data_ready}, 32'd0);
    chk("dis_data_hold", {24'd0, data_out}, 32'h0000_0044);
    rx_enable = 1'b1;
    tick(5);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(5);

    serial_in = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = 1'b1;
      tick(BIT);
    end
    tick(4);
    n_Rst = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, data_ready}, 32'd0);
    chk("mid_rst_ferr", {31'd0, framing_error}, 32'd0);
    chk("mid_rst_ovr", {31'd0, overrun_error}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    n_Rst = 1'b1;
    tick(BIT);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(20);
    chk("sb_drained", sb.size(), 32'd0);

    for (int i = 0; i < 10000 && !done434; i++) tick(1);
    if (!done434) begin
      n_cmp++;
      n_err++;
      $display("FAIL b434_timeout: got not done, expected done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
